// File: rtl/note_hit_scorer_if.sv
// Scoring-stage bus: loader/pitch-detector inputs and HUD/display outputs.
interface note_hit_scorer_if;
    logic        play_en;
    logic [25:0] tempo;
    logic [63:0] notes_in;
    logic        played_valid;
    logic [3:0]  played_note;
    logic        beat_tick;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [15:0] score;
    logic [7:0]  streak;
    logic [7:0]  max_streak;
    logic [9:0]  hits;
    logic [9:0]  misses;
    logic        done;

    modport master (
        output play_en, tempo, notes_in, played_valid, played_note,
        input  beat_tick, hit_pulse, miss_pulse, score, streak, max_streak,
               hits, misses, done
    );

    modport slave (
        input  play_en, tempo, notes_in, played_valid, played_note,
        output beat_tick, hit_pulse, miss_pulse, score, streak, max_streak,
               hits, misses, done
    );
endinterface

// File: rtl/note_hit_scorer.sv
// Beat-window note scorer: times beats from the loader tempo, checks the
// detector strobes against the note due in each window and keeps score.
module note_hit_scorer #(
    parameter int BASE_POINTS = 10,
    parameter int SONG_BEATS  = 128
) (
    input logic              clk,
    input logic              reset,
    note_hit_scorer_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAYING = 2'd1, DONE = 2'd2} state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [25:0] count_r;
    logic [3:0]  target_r;
    logic        load_pending_r;   // first cycle of a window: target comes straight from the loader
    logic        hit_seen_r;
    logic [7:0]  beat_idx_r;
    logic        beat_tick_r;
    logic        hit_pulse_r;
    logic        miss_pulse_r;
    logic [15:0] score_r;
    logic [7:0]  streak_r;
    logic [7:0]  max_streak_r;
    logic [9:0]  hits_r;
    logic [9:0]  misses_r;
    logic        done_r;

    logic [3:0]  cur_target_s;
    logic        match_s;
    logic        window_end_s;
    logic        hit_now_s;
    logic        last_beat_s;
    logic [2:0]  mult_s;
    logic [16:0] points_s;
    logic [16:0] points_sat_s;
    logic [16:0] score_sum_s;
    logic [15:0] score_next_s;
    logic [7:0]  streak_inc_s;
    logic        notes_unused_s;

    // Only the lowest nibble of the note window is due now.
    assign notes_unused_s = ^bus.notes_in[63:4];

    // Window bookkeeping and scoring arithmetic for the closing window.
    always_comb begin
        cur_target_s = load_pending_r ? bus.notes_in[3:0] : target_r;
        match_s      = bus.played_valid && (bus.played_note == cur_target_s) && (cur_target_s != 4'd0);
        window_end_s = (bus.tempo <= 26'd1) || (count_r == (bus.tempo - 26'd1));
        hit_now_s    = hit_seen_r || match_s;
        last_beat_s  = (({1'b0, beat_idx_r} + 9'd1) == 9'(SONG_BEATS));
        if (streak_r[7:3] > 5'd3) begin
            mult_s = 3'd4;
        end else begin
            mult_s = 3'd1 + {1'b0, streak_r[4:3]};
        end
        points_s     = 17'(BASE_POINTS) * {14'd0, mult_s};
        points_sat_s = (points_s > 17'h0FFFF) ? 17'h0FFFF : points_s;
        score_sum_s  = {1'b0, score_r} + points_sat_s;
        score_next_s = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
        streak_inc_s = (streak_r == 8'hFF) ? 8'hFF : (streak_r + 8'd1);
    end

    // Game state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next game state: pause returns to IDLE, the last scored beat ends the song.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.play_en) begin
                    state_next_s = PLAYING;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PLAYING: begin
                if (!bus.play_en) begin
                    state_next_s = IDLE;
                end else if (window_end_s && last_beat_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = PLAYING;
                end
            end
            DONE:    state_next_s = DONE;
            default: state_next_s = IDLE;
        endcase
    end

    // Beat timer, window capture and score/streak counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r        <= 26'd0;
            target_r       <= 4'd0;
            load_pending_r <= 1'b0;
            hit_seen_r     <= 1'b0;
            beat_idx_r     <= 8'd0;
            beat_tick_r    <= 1'b0;
            hit_pulse_r    <= 1'b0;
            miss_pulse_r   <= 1'b0;
            score_r        <= 16'd0;
            streak_r       <= 8'd0;
            max_streak_r   <= 8'd0;
            hits_r         <= 10'd0;
            misses_r       <= 10'd0;
            done_r         <= 1'b0;
        end else begin
            beat_tick_r  <= 1'b0;
            hit_pulse_r  <= 1'b0;
            miss_pulse_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    count_r        <= 26'd0;
                    hit_seen_r     <= 1'b0;
                    load_pending_r <= 1'b0;
                    if (bus.play_en) begin
                        target_r <= bus.notes_in[3:0];
                    end
                end
                PLAYING: begin
                    if (!bus.play_en) begin
                        count_r        <= 26'd0;
                        hit_seen_r     <= 1'b0;
                        load_pending_r <= 1'b0;
                    end else begin
                        load_pending_r <= 1'b0;
                        if (load_pending_r) begin
                            target_r <= bus.notes_in[3:0];
                        end
                        if (window_end_s) begin
                            count_r        <= 26'd0;
                            beat_tick_r    <= 1'b1;
                            hit_seen_r     <= 1'b0;
                            load_pending_r <= 1'b1;
                            beat_idx_r     <= beat_idx_r + 8'd1;
                            if (last_beat_s) begin
                                done_r <= 1'b1;
                            end
                            if (cur_target_s != 4'd0) begin
                                if (hit_now_s) begin
                                    hit_pulse_r <= 1'b1;
                                    hits_r      <= (hits_r == 10'h3FF) ? hits_r : (hits_r + 10'd1);
                                    streak_r    <= streak_inc_s;
                                    score_r     <= score_next_s;
                                    if (streak_inc_s > max_streak_r) begin
                                        max_streak_r <= streak_inc_s;
                                    end
                                end else begin
                                    miss_pulse_r <= 1'b1;
                                    misses_r     <= (misses_r == 10'h3FF) ? misses_r : (misses_r + 10'd1);
                                    streak_r     <= 8'd0;
                                end
                            end
                        end else begin
                            count_r <= count_r + 26'd1;
                            if (match_s) begin
                                hit_seen_r <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b1;
                end
                default: begin
                    count_r <= 26'd0;
                end
            endcase
        end
    end

    assign bus.beat_tick  = beat_tick_r;
    assign bus.hit_pulse  = hit_pulse_r;
    assign bus.miss_pulse = miss_pulse_r;
    assign bus.score      = score_r;
    assign bus.streak     = streak_r;
    assign bus.max_streak = max_streak_r;
    assign bus.hits       = hits_r;
    assign bus.misses     = misses_r;
    assign bus.done       = done_r;
endmodule

// File: doc/note_hit_scorer.md
# note_hit_scorer

Gameplay scoring stage downstream of the musical score loader. It runs a beat timer from the loader's tempo value and captures the note due in each beat from the lowest nibble of the loader's 64-bit note window. It compares that note against note strobes from the pitch detector and drives hit/miss pulses, streak and score counters, and end-of-song status to the video display and HUD logic.

## Interface
- BASE_POINTS, 10: points awarded for a hit at multiplier 1
- SONG_BEATS, 128: number of scored beat windows before DONE
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- play_en  in  1  level; high = game running, low = pause
- tempo  in  26  beat period in clk cycles (loader tempo_out)
- notes_in  in  64  loader note window; [3:0] = note due now, 0 = rest
- played_valid  in  1  one-cycle strobe from pitch detector
- played_note  in  4  detected note, valid with played_valid
- beat_tick  out  1  one-cycle pulse at end of each beat window
- hit_pulse  out  1  one-cycle pulse, window scored as hit
- miss_pulse  out  1  one-cycle pulse, window scored as miss
- score  out  16  accumulated score, saturating
- streak  out  8  consecutive hits, saturating at 255
- max_streak  out  8  highest streak this song
- hits  out  10  hit count, saturating at 1023
- misses  out  10  miss count, saturating at 1023
- done  out  1  level; song finished

## Operation
- States: IDLE, PLAYING, DONE. Reset -> IDLE. All outputs reset to 0.
- IDLE: beat counter held at 0, window flags cleared. play_en=1 -> PLAYING. On entry, target <= notes_in[3:0].
- PLAYING: beat counter increments each cycle. When count == tempo-1, or when tempo is 0 or 1, assert beat_tick and set count to 0. The window then closes and is evaluated. play_en=0 -> IDLE. The counter restarts from 0 and the current window is discarded: no pulse, no counter change.
- Window capture: hit_seen <= 1 when played_valid && played_note == target && target != 0. Any strobe, including the one on the tick cycle, counts toward the window that closes on that tick.
- Evaluation at tick:
  - target == 0 (rest): not scored, no pulse, streak unchanged.
  - hit_seen: hit_pulse, hits+1, streak+1, score += BASE_POINTS*mult.
  - otherwise: miss_pulse, misses+1, streak <= 0.
- Multiplier: mult = 1 + min(streak_before_increment >> 3, 3), range 1..4. Products and sums are computed at 17 bits and saturate to 16'hFFFF.
- max_streak <= max(max_streak, new streak) on each hit.
- Every window, rest or not, increments beat_idx (8-bit). When a tick brings beat_idx to SONG_BEATS -> DONE.
- DONE: done=1. Counters and score are frozen, beat_tick is suppressed, and play_en is ignored. Only reset exits DONE.
- Reset mid-song clears everything in the same cycle, with no pulses.

## Timing
- beat_tick, hit_pulse and miss_pulse are registered and fire in the same cycle, one cycle after the count reaches tempo-1.
- The next window's target is sampled from notes_in[3:0] one cycle after beat_tick. This follows the loader's one-cycle shift latency. A strobe landing between the tick and the target sample is compared against the new target.
- Score, streak, hit and miss counts update on the same edge as their pulse.
- The window period is max(tempo,1) cycles.
- Because play_en pauses restart the counter, the block drifts from the loader's beat. Firmware resets both blocks together to realign.

## Test plan
- Reset mid-window with hits=5, score=120 -> next cycle all outputs 0, state IDLE, no pulse.
- tempo=8, note 3, played_note=3 strobe at cycle 4 of the window -> hit_pulse with beat_tick, score=10, streak=1, hits=1.
- Target 5, strobes of 4 then none -> miss_pulse, misses=1, streak=0. A rest target with a strobe -> no pulse, counters unchanged.
- Nine consecutive hits -> score=10×8+20=100 (ninth hit at mult 2), streak=9, max_streak=9. A miss then follows -> streak=0, max_streak=9.
- Strobe exactly on the tick cycle -> counted in the closing window. A strobe the cycle after the tick -> compared against the next target.
- SONG_BEATS=4, tempo=1 -> four ticks then done=1. No further ticks while done, and play_en toggling is ignored until reset.
